arm_axis_ctrl: RTL and testbench

Multi-axis stepper control peripheral for the arm: one register-mapped block drives `N_AXES` step/dir drivers from the shared command bus. It adds three things over the single-axis controller: per-axis linear acceleration ramps, fixed-width step pulses, and automatic stop on limit or fault. It sits on the Uniboard databus beside the other peripherals.

---
 rtl/arm_pkg.sv | 37 +++
 rtl/arm_axis_core.sv | 171 +++++++++++++++++
 rtl/arm_axis_ctrl.sv | 98 +++++++++
 tb/tb_arm_axis_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and types for the multi-axis stepper controller.
package arm_pkg;

  // Per-axis register offsets within an 8-byte axis window
  localparam logic [2:0] OFF_CONFIG     = 3'd0;
  localparam logic [2:0] OFF_STATUS     = 3'd1;
  localparam logic [2:0] OFF_DIV_TARGET = 3'd2;
  localparam logic [2:0] OFF_STEPS      = 3'd3;
  localparam logic [2:0] OFF_DIV_START  = 3'd4;
  localparam logic [2:0] OFF_ACCEL      = 3'd5;

  // CONFIG bit indices (MS occupies [2:0])
  localparam int unsigned CFG_STEPPOL = 3;
  localparam int unsigned CFG_LIMSTOP = 4;
  localparam int unsigned CFG_DIR     = 5;
  localparam int unsigned CFG_EN      = 6;
  localparam int unsigned CFG_GO      = 7;

  // STATUS bit indices
  localparam int unsigned ST_LIMIT    = 0;
  localparam int unsigned ST_FAULT    = 1;
  localparam int unsigned ST_STEPPING = 2;
  localparam int unsigned ST_RAMPING  = 3;
  localparam int unsigned ST_LIMHIT   = 4;
  localparam int unsigned ST_DONE     = 5;

  // Reset values
  localparam logic [7:0]  CONFIG_RST = 8'h3A;
  localparam logic [31:0] DIV_RST    = 32'd12000;

  typedef enum logic {IDLE, RUN} axis_state_t;

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arm_axis_core.sv
// One stepper axis: register file, IDLE/RUN sequencer, ramp arithmetic and pulse timer.
module arm_axis_core
  import arm_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 24
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        pause,
  input  logic        fault,
  input  logic        limitn,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_off,
  output logic [31:0] rd_val,
  output logic [2:0]  rd_size,
  output logic        step_line,
  output logic        dir,
  output logic        en,
  output logic [2:0]  microstep
);

  localparam logic [31:0] MIN_DIV = 32'(2 * PULSE_CYCLES);
  localparam int unsigned PW      = $clog2(PULSE_CYCLES + 1);

  axis_state_t   state_q, state_d;
  logic [7:0]    config_q, config_d, cfg_eff;
  logic [31:0]   div_target_q, div_target_d;
  logic [31:0]   steps_q, steps_d, steps_eff;
  logic [31:0]   div_start_q, div_start_d;
  logic [31:0]   accel_q, accel_d;
  logic [31:0]   cur_div_q, cur_div_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          limhit_q, limhit_d;
  logic          done_q, done_d;
  logic          wr_cfg, wr_steps;
  logic [31:0]   eff_target, eff_start, ramp_div;
  logic          lim_stop, stop, step_evt, int_step;
  logic [7:0]    status;

  // Next-state for registers, sequencer, ramp and pulse timer
  always_comb begin
    wr_cfg     = wr_en && (wr_off == OFF_CONFIG);
    wr_steps   = wr_en && (wr_off == OFF_STEPS);
    cfg_eff    = wr_cfg ? wr_data[7:0] : config_q;
    steps_eff  = wr_steps ? wr_data : steps_q;
    eff_target = max32(div_target_q, MIN_DIV);
    eff_start  = max32(div_start_q, eff_target);
    // Saturating decrement toward the target divisor
    ramp_div   = max32((cur_div_q > accel_q) ? cur_div_q - accel_q : 32'd0, eff_target);
    lim_stop   = config_q[CFG_LIMSTOP] & ~limitn;
    stop       = lim_stop | fault;

    state_d      = state_q;
    config_d     = cfg_eff;
    steps_d      = steps_eff;
    div_target_d = (wr_en && wr_off == OFF_DIV_TARGET) ? wr_data : div_target_q;
    div_start_d  = (wr_en && wr_off == OFF_DIV_START) ? wr_data : div_start_q;
    accel_d      = (wr_en && wr_off == OFF_ACCEL) ? wr_data : accel_q;
    cur_div_d    = cur_div_q;
    cnt_d        = cnt_q;
    limhit_d     = limhit_q & ~wr_cfg;
    done_d       = done_q & ~wr_cfg;
    step_evt     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start decision sees a GO or STEPS write in the same cycle, so the first
        // step lands exactly cur_div clocks after the commit edge.
        if (!pause && cfg_eff[CFG_GO] && (steps_eff != 32'd0) && !stop) begin
          state_d   = RUN;
          cur_div_d = eff_start;
          cnt_d     = eff_start - 32'd1;
        end
      end
      RUN: begin
        // Stops and GO=0 are honoured even while paused
        if (stop) begin
          state_d          = IDLE;
          config_d[CFG_GO] = 1'b0;
          if (lim_stop) limhit_d = 1'b1;
        end else if (!cfg_eff[CFG_GO]) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (cnt_q == 32'd0) begin
            step_evt  = 1'b1;
            cur_div_d = ramp_div;
            cnt_d     = ramp_div - 32'd1;
            if (!wr_steps && steps_q != 32'd0) steps_d = steps_q - 32'd1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
          if (steps_d == 32'd0) begin
            state_d          = IDLE;
            config_d[CFG_GO] = 1'b0;
            done_d           = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A started pulse always runs to completion
    if (step_evt)              pulse_d = PW'(PULSE_CYCLES);
    else if (pulse_q != '0)    pulse_d = pulse_q - PW'(1);
    else                       pulse_d = pulse_q;
  end

  // State register with synchronous reset
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      config_q     <= CONFIG_RST;
      div_target_q <= DIV_RST;
      steps_q      <= 32'd0;
      div_start_q  <= DIV_RST;
      accel_q      <= 32'd0;
      cur_div_q    <= DIV_RST;
      cnt_q        <= 32'd0;
      pulse_q      <= '0;
      limhit_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      config_q     <= config_d;
      div_target_q <= div_target_d;
      steps_q      <= steps_d;
      div_start_q  <= div_start_d;
      accel_q      <= accel_d;
      cur_div_q    <= cur_div_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
      limhit_q     <= limhit_d;
      done_q       <= done_d;
    end
  end

  // Driver outputs and status word
  always_comb begin
    int_step            = (pulse_q != '0);
    step_line           = int_step ^ ~config_q[CFG_STEPPOL];
    dir                 = config_q[CFG_DIR];
    en                  = ~config_q[CFG_EN];
    microstep           = config_q[2:0];
    status              = 8'd0;
    status[ST_LIMIT]    = ~limitn;
    status[ST_FAULT]    = fault;
    status[ST_STEPPING] = (state_q == RUN) & ~pause;
    status[ST_RAMPING]  = cur_div_q > eff_target;
    status[ST_LIMHIT]   = limhit_q;
    status[ST_DONE]     = done_q;
  end

  // Register read mux; offsets 6-7 return size 0
  always_comb begin
    rd_val  = 32'd0;
    rd_size = 3'd0;
    case (rd_off)
      OFF_CONFIG:     begin rd_val = {24'd0, config_q}; rd_size = 3'd1; end
      OFF_STATUS:     begin rd_val = {24'd0, status};   rd_size = 3'd1; end
      OFF_DIV_TARGET: begin rd_val = div_target_q;      rd_size = 3'd4; end
      OFF_STEPS:      begin rd_val = steps_q;           rd_size = 3'd4; end
      OFF_DIV_START:  begin rd_val = div_start_q;       rd_size = 3'd4; end
      OFF_ACCEL:      begin rd_val = accel_q;           rd_size = 3'd4; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/arm_axis_ctrl.sv
// Multi-axis stepper peripheral: bus edge detect, address decode and N_AXES axis cores.
module arm_axis_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned N_AXES       = 4,
  parameter logic [7:0]  BASE_ADDR    = 8'h00,
  parameter int unsigned PULSE_CYCLES = 24
) (
  input  logic                  clk_12MHz,
  input  logic                  reset,
  inout  tri   [31:0]           databus,
  output tri   [2:0]            reg_size,
  input  logic [7:0]            register_addr,
  input  logic                  rw,
  input  logic                  select,
  input  logic                  pause,
  output logic [N_AXES-1:0]     step_line,
  output logic [N_AXES-1:0]     dir,
  output logic [N_AXES-1:0]     en,
  output logic [3*N_AXES-1:0]   microstep,
  input  logic [N_AXES-1:0]     fault,
  input  logic [N_AXES-1:0]     limitn
);

  logic        prev_select_q;
  logic        sel_rise, hit;
  logic [8:0]  rel;
  logic [2:0]  sel_axis, sel_off;
  logic [31:0] rd_data_q, rd_mux;
  logic [2:0]  rd_size_q, size_mux;
  logic [31:0] axis_val  [N_AXES];
  logic [2:0]  axis_size [N_AXES];

  // Address decode; 9-bit difference so addresses below BASE_ADDR wrap out of range
  always_comb begin
    sel_rise = select & ~prev_select_q;
    rel      = {1'b0, register_addr} - {1'b0, BASE_ADDR};
    hit      = rel < 9'(8 * N_AXES);
    sel_axis = rel[5:3];
    sel_off  = rel[2:0];
  end

  // Read data select across axes
  always_comb begin
    rd_mux   = 32'd0;
    size_mux = 3'd0;
    for (int i = 0; i < N_AXES; i++) begin
      if (hit && sel_axis == 3'(i)) begin
        rd_mux   = axis_val[i];
        size_mux = axis_size[i];
      end
    end
  end

  // Select edge detector and read latch
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      prev_select_q <= 1'b0;
      rd_data_q     <= 32'd0;
      rd_size_q     <= 3'd0;
    end else begin
      prev_select_q <= select;
      if (sel_rise && rw) begin
        rd_data_q <= rd_mux;
        rd_size_q <= size_mux;
      end
    end
  end

  assign databus  = (select && rw) ? rd_data_q : 'z;
  assign reg_size = select ? rd_size_q : 'z;

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    logic wr_en_ax;
    assign wr_en_ax = sel_rise & ~rw & hit & (sel_axis == 3'(i));

    arm_axis_core #(
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_core (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .pause     (pause),
      .fault     (fault[i]),
      .limitn    (limitn[i]),
      .wr_en     (wr_en_ax),
      .wr_off    (sel_off),
      .wr_data   (databus),
      .rd_off    (sel_off),
      .rd_val    (axis_val[i]),
      .rd_size   (axis_size[i]),
      .step_line (step_line[i]),
      .dir       (dir[i]),
      .en        (en[i]),
      .microstep (microstep[3*i +: 3])
    );
  end

endmodule

// File: tb/tb_arm_axis_ctrl.sv
// Directed self-checking bench for arm_axis_ctrl (4 axes, 24-clock pulses).
module tb_arm_axis_ctrl;

  logic        clk_12MHz = 1'b0;
  logic        reset;
  tri   [31:0] databus;
  tri   [2:0]  reg_size;
  logic [7:0]  register_addr;
  logic        rw, select, pause;
  logic [3:0]  step_line, dir, en, fault, limitn;
  logic [11:0] microstep;
  logic [31:0] bus_drv;
  logic        bus_oe;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] rv;
  logic [2:0]  rs;

  assign databus = bus_oe ? bus_drv : 'z;

  arm_axis_ctrl #(
    .N_AXES       (4),
    .BASE_ADDR    (8'h00),
    .PULSE_CYCLES (24)
  ) dut (
    .clk_12MHz     (clk_12MHz),
    .reset         (reset),
    .databus       (databus),
    .reg_size      (reg_size),
    .register_addr (register_addr),
    .rw            (rw),
    .select        (select),
    .pause         (pause),
    .step_line     (step_line),
    .dir           (dir),
    .en            (en),
    .microstep     (microstep),
    .fault         (fault),
    .limitn        (limitn)
  );

  always #5 clk_12MHz = ~clk_12MHz;
  always @(posedge clk_12MHz) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    select = 1'b0;
    @(posedge clk_12MHz); #1;
    register_addr = a; rw = 1'b0; bus_drv = d; bus_oe = 1'b1; select = 1'b1;
    @(posedge clk_12MHz); #1;
    select = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] v, output logic [2:0] s);
    select = 1'b0; bus_oe = 1'b0;
    @(posedge clk_12MHz); #1;
    register_addr = a; rw = 1'b1; select = 1'b1;
    @(posedge clk_12MHz); #1;
    v = databus; s = reg_size;
    select = 1'b0;
  endtask

  // Returns the cycle stamp of the next rising edge of step_line[ax]
  task automatic wait_rise(input int ax, input int budget, output int t, output bit ok);
    logic prev;
    prev = step_line[ax];
    ok = 1'b0; t = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk_12MHz); #1;
      if (!prev && step_line[ax]) begin ok = 1'b1; t = cyc; break; end
      prev = step_line[ax];
    end
  endtask

  task automatic wait_fall(input int ax, input int budget, output int t, output bit ok);
    logic prev;
    prev = step_line[ax];
    ok = 1'b0; t = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk_12MHz); #1;
      if (prev && !step_line[ax]) begin ok = 1'b1; t = cyc; break; end
      prev = step_line[ax];
    end
  endtask

  task automatic test_reset();
    n_checks++; if (step_line !== 4'h0) $display("FAIL rst_step: got %h want 0", step_line); else n_pass++;
    n_checks++; if (dir !== 4'hF) $display("FAIL rst_dir: got %h want f", dir); else n_pass++;
    n_checks++; if (en !== 4'hF) $display("FAIL rst_en: got %h want f", en); else n_pass++;
    n_checks++; if (microstep !== 12'h492) $display("FAIL rst_ms: got %h want 492", microstep); else n_pass++;
    reset = 1'b0;
    bus_read(8'd0, rv, rs);
    n_checks++; if (rv !== 32'h3A || rs !== 3'd1) $display("FAIL rst_config: got %h/%0d want 3a/1", rv, rs); else n_pass++;
    bus_read(8'd9, rv, rs);
    n_checks++; if (rv !== 32'h0 || rs !== 3'd1) $display("FAIL rst_status: got %h/%0d want 0/1", rv, rs); else n_pass++;
    bus_read(8'd28, rv, rs);
    n_checks++; if (rv !== 32'd12000 || rs !== 3'd4) $display("FAIL rst_divstart: got %0d/%0d want 12000/4", rv, rs); else n_pass++;
  endtask

  task automatic test_bus();
    bus_read(8'd18, rv, rs);
    n_checks++; if (rv !== 32'd12000 || rs !== 3'd4) $display("FAIL bus_ax2_target: got %0d/%0d want 12000/4", rv, rs); else n_pass++;
    bus_read(8'd7, rv, rs);
    n_checks++; if (rv !== 32'd0 || rs !== 3'd0) $display("FAIL bus_off7: got %0d/%0d want 0/0", rv, rs); else n_pass++;
    bus_write(8'd6, 32'hFFFF_FFFF);
    bus_read(8'd6, rv, rs);
    n_checks++; if (rv !== 32'd0 || rs !== 3'd0) $display("FAIL bus_off6: got %0d/%0d want 0/0", rv, rs); else n_pass++;
    bus_read(8'd32, rv, rs);
    n_checks++; if (rv !== 32'd0 || rs !== 3'd0) $display("FAIL bus_unmapped: got %0d/%0d want 0/0", rv, rs); else n_pass++;
  endtask

  task automatic test_basic();
    int c0, r1, r2, r3, f1, t;
    bit ok;
    bus_write(8'd2, 32'd100);
    bus_write(8'd4, 32'd100);
    bus_write(8'd3, 32'd3);
    bus_write(8'd0, 32'hBA);
    c0 = cyc;
    wait_rise(0, 300, r1, ok);
    n_checks++; if (!ok || r1 - c0 != 100) $display("FAIL basic_first: got %0d want 100", r1 - c0); else n_pass++;
    wait_fall(0, 100, f1, ok);
    n_checks++; if (!ok || f1 - r1 != 24) $display("FAIL basic_width: got %0d want 24", f1 - r1); else n_pass++;
    wait_rise(0, 300, r2, ok);
    n_checks++; if (!ok || r2 - r1 != 100) $display("FAIL basic_period2: got %0d want 100", r2 - r1); else n_pass++;
    wait_rise(0, 300, r3, ok);
    n_checks++; if (!ok || r3 - r2 != 100) $display("FAIL basic_period3: got %0d want 100", r3 - r2); else n_pass++;
    bus_read(8'd3, rv, rs);
    n_checks++; if (rv !== 32'd0) $display("FAIL basic_steps: got %0d want 0", rv); else n_pass++;
    bus_read(8'd0, rv, rs);
    n_checks++; if (rv !== 32'h3A) $display("FAIL basic_go_clr: got %h want 3a", rv); else n_pass++;
    bus_read(8'd1, rv, rs);
    n_checks++; if (rv !== 32'h20) $display("FAIL basic_done: got %h want 20", rv); else n_pass++;
    wait_rise(0, 250, t, ok);
    n_checks++; if (ok) $display("FAIL basic_extra_step: got step at %0d want none", t); else n_pass++;
  endtask

  task automatic test_ramp();
    int want [5] = '{1000, 750, 500, 400, 400};
    int prev, r;
    bit ok;
    bus_write(8'd5, 32'd250);
    bus_write(8'd2, 32'd400);
    bus_write(8'd4, 32'd1000);
    bus_write(8'd3, 32'd5);
    bus_write(8'd0, 32'hBA);
    prev = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_rise(0, 1200, r, ok);
      n_checks++;
      if (!ok || r - prev != want[k]) $display("FAIL ramp_int%0d: got %0d want %0d", k, r - prev, want[k]);
      else n_pass++;
      prev = r;
      if (k == 0) begin
        bus_read(8'd1, rv, rs);
        n_checks++; if (rv !== 32'h0C) $display("FAIL ramp_status0: got %h want 0c", rv); else n_pass++;
      end
      if (k == 2) begin
        bus_read(8'd1, rv, rs);
        n_checks++; if (rv !== 32'h04) $display("FAIL ramp_status2: got %h want 04", rv); else n_pass++;
      end
    end
    bus_read(8'd1, rv, rs);
    n_checks++; if (rv !== 32'h20) $display("FAIL ramp_done: got %h want 20", rv); else n_pass++;
  endtask

  task automatic test_limit();
    int r, f, t;
    bit ok;
    bus_write(8'd5, 32'd0);
    bus_write(8'd2, 32'd100);
    bus_write(8'd4, 32'd100);
    bus_write(8'd3, 32'd10);
    bus_write(8'd0, 32'hBA);
    for (int k = 0; k < 4; k++) wait_rise(0, 300, r, ok);
    n_checks++; if (!ok) $display("FAIL lim_4th: got no step want step"); else n_pass++;
    limitn[0] = 1'b0;
    wait_fall(0, 100, f, ok);
    n_checks++; if (!ok || f - r != 24) $display("FAIL lim_pulse_done: got %0d want 24", f - r); else n_pass++;
    wait_rise(0, 200, t, ok);
    n_checks++; if (ok) $display("FAIL lim_5th: got step at %0d want none", t); else n_pass++;
    bus_read(8'd3, rv, rs);
    n_checks++; if (rv !== 32'd6) $display("FAIL lim_steps: got %0d want 6", rv); else n_pass++;
    bus_read(8'd0, rv, rs);
    n_checks++; if (rv !== 32'h3A) $display("FAIL lim_go: got %h want 3a", rv); else n_pass++;
    bus_read(8'd1, rv, rs);
    n_checks++; if (rv !== 32'h11) $display("FAIL lim_status: got %h want 11", rv); else n_pass++;
    limitn[0] = 1'b1;
  endtask

  task automatic test_pause();
    int c0, r1, r2;
    bit ok;
    bus_write(8'd2, 32'd200);
    bus_write(8'd4, 32'd200);
    bus_write(8'd3, 32'd2);
    bus_write(8'd0, 32'hBA);
    c0 = cyc;
    wait_rise(0, 400, r1, ok);
    n_checks++; if (!ok || r1 - c0 != 200) $display("FAIL pause_first: got %0d want 200", r1 - c0); else n_pass++;
    repeat (50) begin @(posedge clk_12MHz); #1; end
    pause = 1'b1;
    bus_read(8'd1, rv, rs);
    n_checks++; if (rv !== 32'h00) $display("FAIL pause_status: got %h want 00", rv); else n_pass++;
    repeat (48) begin @(posedge clk_12MHz); #1; end
    pause = 1'b0;
    wait_rise(0, 400, r2, ok);
    n_checks++; if (!ok || r2 - r1 != 250) $display("FAIL pause_delay: got %0d want 250", r2 - r1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c1, c3;
    int q1 [$];
    int q3 [$];
    logic [3:0] prev;
    bus_write(8'd10, 32'd48);
    bus_write(8'd12, 32'd48);
    bus_write(8'd11, 32'd4);
    bus_write(8'd26, 32'd60);
    bus_write(8'd28, 32'd60);
    bus_write(8'd27, 32'd3);
    bus_write(8'd8, 32'hBA);
    c1 = cyc;
    bus_write(8'd24, 32'hBA);
    c3 = cyc;
    prev = step_line;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk_12MHz); #1;
      if (!prev[1] && step_line[1]) q1.push_back(cyc);
      if (!prev[3] && step_line[3]) q3.push_back(cyc);
      prev = step_line;
    end
    n_checks++; if (q1.size() != 4) $display("FAIL ax1_count: got %0d want 4", q1.size()); else n_pass++;
    n_checks++; if (q3.size() != 3) $display("FAIL ax3_count: got %0d want 3", q3.size()); else n_pass++;
    if (q1.size() == 4) begin
      n_checks++; if (q1[0] - c1 != 48) $display("FAIL ax1_first: got %0d want 48", q1[0] - c1); else n_pass++;
      n_checks++; if (q1[3] - q1[2] != 48) $display("FAIL ax1_period: got %0d want 48", q1[3] - q1[2]); else n_pass++;
    end
    if (q3.size() == 3) begin
      n_checks++; if (q3[0] - c3 != 60) $display("FAIL ax3_first: got %0d want 60", q3[0] - c3); else n_pass++;
      n_checks++; if (q3[2] - q3[1] != 60) $display("FAIL ax3_period: got %0d want 60", q3[2] - q3[1]); else n_pass++;
    end
  endtask

  task automatic test_outputs();
    bus_write(8'd16, 32'h45);
    n_checks++; if (step_line[2] !== 1'b1) $display("FAIL out_steppol: got %b want 1", step_line[2]); else n_pass++;
    n_checks++; if (dir[2] !== 1'b0 || en[2] !== 1'b0) $display("FAIL out_dir_en: got %b%b want 00", dir[2], en[2]); else n_pass++;
    n_checks++; if (microstep[8:6] !== 3'b101) $display("FAIL out_ms: got %b want 101", microstep[8:6]); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    int r;
    bit ok;
    bus_write(8'd5, 32'd7);
    bus_write(8'd2, 32'd100);
    bus_write(8'd4, 32'd100);
    bus_write(8'd3, 32'd5);
    bus_write(8'd0, 32'hBA);
    wait_rise(0, 300, r, ok);
    repeat (5) begin @(posedge clk_12MHz); #1; end
    n_checks++; if (step_line[0] !== 1'b1) $display("FAIL mid_pulse_high: got %b want 1", step_line[0]); else n_pass++;
    reset = 1'b1;
    @(posedge clk_12MHz); #1;
    n_checks++; if (step_line !== 4'h0) $display("FAIL mid_rst_step: got %h want 0", step_line); else n_pass++;
    n_checks++; if (dir !== 4'hF || en !== 4'hF) $display("FAIL mid_rst_dir_en: got %h/%h want f/f", dir, en); else n_pass++;
    n_checks++; if (microstep !== 12'h492) $display("FAIL mid_rst_ms: got %h want 492", microstep); else n_pass++;
    reset = 1'b0;
    bus_read(8'd0, rv, rs);
    n_checks++; if (rv !== 32'h3A) $display("FAIL mid_rst_config: got %h want 3a", rv); else n_pass++;
    bus_read(8'd3, rv, rs);
    n_checks++; if (rv !== 32'd0) $display("FAIL mid_rst_steps: got %0d want 0", rv); else n_pass++;
    bus_read(8'd5, rv, rs);
    n_checks++; if (rv !== 32'd0) $display("FAIL mid_rst_accel: got %0d want 0", rv); else n_pass++;
    bus_read(8'd2, rv, rs);
    n_checks++; if (rv !== 32'd12000) $display("FAIL mid_rst_target: got %0d want 12000", rv); else n_pass++;
    bus_read(8'd1, rv, rs);
    n_checks++; if (rv !== 32'h0) $display("FAIL mid_rst_status: got %h want 0", rv); else n_pass++;
    bus_read(8'd16, rv, rs);
    n_checks++; if (rv !== 32'h3A) $display("FAIL mid_rst_ax2_cfg: got %h want 3a", rv); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; select = 1'b0; rw = 1'b0; pause = 1'b0;
    register_addr = 8'd0; bus_drv = 32'd0; bus_oe = 1'b0;
    fault = 4'h0; limitn = 4'hF;
    repeat (3) begin @(posedge clk_12MHz); #1; end
    test_reset();
    test_bus();
    test_basic();
    test_ramp();
    test_limit();
    test_pause();
    test_back_to_back();
    test_outputs();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
